// File: rtl/nab_axil_pkg.sv
// Shared register map and response codes for the bridge AXI4-Lite register file.
package nab_axil_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned AUX_W     = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_CTRL    = 3'd0;
  localparam reg_idx_t REG_NET_OUT = 3'd1;
  localparam reg_idx_t REG_CFG0    = 3'd2;
  localparam reg_idx_t REG_CFG1    = 3'd3;
  localparam reg_idx_t REG_AUX0    = 3'd4;
  localparam reg_idx_t REG_AUX1    = 3'd5;
  localparam reg_idx_t REG_AUX2    = 3'd6;
  localparam reg_idx_t REG_AUX3    = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bit k set means register k is host-writable.
  localparam logic [7:0] REG_RW_MASK = 8'b0000_1101;

  // True when the decoded word index names a writable register.
  function automatic logic is_rw(input reg_idx_t idx);
    return REG_RW_MASK[idx];
  endfunction

endpackage

// File: rtl/nab_axil_wstrb_merge.sv
// Byte-enable merge of a register's current value with incoming write data.
module nab_axil_wstrb_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   merged_c_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  // Take each enabled byte from the write data, keep the rest.
  always_comb begin
    merged_c_o = old_i;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (wstrb_i[b]) begin
        merged_c_o[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/nab_axil_regfile.sv
// AXI4-Lite responder exposing control/config registers and read-only status to the bridge.
module nab_axil_regfile
  import nab_axil_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [DATA_W-1:0]   ctrl_reg,
  output logic [DATA_W-1:0]   cfg0_reg,
  output logic [DATA_W-1:0]   cfg1_reg,
  output logic                ctrl_wr_pulse,
  input  logic [DATA_W-1:0]   net_out,
  input  logic [63:0]         aux_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              pulse_q, pulse_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] cfg0_q, cfg0_d;
  logic [DATA_W-1:0] cfg1_q, cfg1_d;

  logic [IDX_W-1:0]  widx_c, ridx_c;
  logic              waddr_ok_c, raddr_ok_c;
  logic [DATA_W-1:0] ctrl_merge_c, cfg0_merge_c, cfg1_merge_c;
  logic [DATA_W-1:0] rmux_c;

  // Word decode: only aligned addresses inside the 8-word window are in range.
  assign widx_c     = S_AXI_AWADDR[IDX_W+1:2];
  assign ridx_c     = S_AXI_ARADDR[IDX_W+1:2];
  assign waddr_ok_c = (S_AXI_AWADDR[ADDR_W-1:IDX_W+2] == '0) && (S_AXI_AWADDR[1:0] == 2'b00);
  assign raddr_ok_c = (S_AXI_ARADDR[ADDR_W-1:IDX_W+2] == '0) && (S_AXI_ARADDR[1:0] == 2'b00);

  nab_axil_wstrb_merge #(.DATA_W(DATA_W)) u_merge_ctrl (
    .old_i(ctrl_q), .wdata_i(S_AXI_WDATA), .wstrb_i(S_AXI_WSTRB), .merged_c_o(ctrl_merge_c)
  );
  nab_axil_wstrb_merge #(.DATA_W(DATA_W)) u_merge_cfg0 (
    .old_i(cfg0_q), .wdata_i(S_AXI_WDATA), .wstrb_i(S_AXI_WSTRB), .merged_c_o(cfg0_merge_c)
  );
  nab_axil_wstrb_merge #(.DATA_W(DATA_W)) u_merge_cfg1 (
    .old_i(cfg1_q), .wdata_i(S_AXI_WDATA), .wstrb_i(S_AXI_WSTRB), .merged_c_o(cfg1_merge_c)
  );

  // Write channel: ready pulse, register update on the ready cycle, then the held response.
  always_comb begin
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = 1'b0;
    ctrl_d    = ctrl_q;
    cfg0_d    = cfg0_q;
    cfg1_d    = cfg1_q;
    if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q) begin
      awready_d = 1'b1;
    end
    if (awready_q) begin
      bvalid_d = 1'b1;
      bresp_d  = waddr_ok_c ? RESP_OKAY : RESP_SLVERR;
      if (waddr_ok_c && is_rw(widx_c)) begin
        case (widx_c)
          REG_CTRL: ctrl_d = ctrl_merge_c;
          REG_CFG0: cfg0_d = cfg0_merge_c;
          REG_CFG1: cfg1_d = cfg1_merge_c;
          default:  ;
        endcase
      end
      if (waddr_ok_c && (widx_c == REG_CTRL)) begin
        pulse_d = 1'b1;
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Read source select; read-only inputs are taken live at the capture edge.
  always_comb begin
    rmux_c = '0;
    case (ridx_c)
      REG_CTRL:    rmux_c = ctrl_q;
      REG_NET_OUT: rmux_c = net_out;
      REG_CFG0:    rmux_c = cfg0_q;
      REG_CFG1:    rmux_c = cfg1_q;
      REG_AUX0:    rmux_c = DATA_W'(aux_data[0*AUX_W +: AUX_W]);
      REG_AUX1:    rmux_c = DATA_W'(aux_data[1*AUX_W +: AUX_W]);
      REG_AUX2:    rmux_c = DATA_W'(aux_data[2*AUX_W +: AUX_W]);
      REG_AUX3:    rmux_c = DATA_W'(aux_data[3*AUX_W +: AUX_W]);
      default:     rmux_c = '0;
    endcase
  end

  // Read channel: ready pulse, data capture on the ready cycle, then the held response.
  always_comb begin
    arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = raddr_ok_c ? rmux_c : '0;
      rresp_d  = raddr_ok_c ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      pulse_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      cfg0_q    <= '0;
      cfg1_q    <= '0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      cfg0_q    <= cfg0_d;
      cfg1_q    <= cfg1_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign ctrl_reg      = ctrl_q;
  assign cfg0_reg      = cfg0_q;
  assign cfg1_reg      = cfg1_q;
  assign ctrl_wr_pulse = pulse_q;

endmodule

// File: tb/tb_nab_axil_regfile.sv
// Self-checking bench for nab_axil_regfile with a word/byte-level register model.
module tb_nab_axil_regfile;

  logic        clk;
  logic        rst_n;
  logic [8:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, ctrl_reg, cfg0_reg, cfg1_reg, net_out;
  logic        ctrl_wr_pulse;
  logic [63:0] aux_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [8];

  nab_axil_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_reg(ctrl_reg), .cfg0_reg(cfg0_reg), .cfg1_reg(cfg1_reg),
    .ctrl_wr_pulse(ctrl_wr_pulse), .net_out(net_out), .aux_data(aux_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic bit addr_ok(input logic [8:0] a);
    return (a < 9'd32) && ((a % 4) == 0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [8:0] a);
    int idx;
    if (!addr_ok(a)) return 32'h0;
    idx = int'(a) / 4;
    if (idx == 1) return net_out;
    if (idx >= 4) return 32'((aux_data >> (16 * (idx - 4))) & 64'hFFFF);
    return model[idx];
  endfunction

  task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (!addr_ok(a)) return;
    idx = int'(a) / 4;
    if (idx != 0 && idx != 2 && idx != 3) return;
    for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic wait_awready(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (awready && wready) begin lat = n; break; end
    end
  endtask

  task automatic wait_arready(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (arready) begin lat = n; break; end
    end
  endtask

  // Full write transaction; reports what it observed for the caller to judge.
  task automatic bus_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [1:0] resp, output logic bv_next,
                           output logic rdy_gone, output int pulses, output logic bv_clear);
    pulses = 0; resp = 2'b11; bv_next = 1'b0; bv_clear = 1'b0; rdy_gone = 1'b0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_awready(lat);
    if (ctrl_wr_pulse) pulses++;
    if (lat < 0) begin awvalid = 1'b0; wvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    bv_next = bvalid; resp = bresp; rdy_gone = !awready && !wready;
    if (ctrl_wr_pulse) pulses++;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; bv_clear = !bvalid;
    if (ctrl_wr_pulse) pulses++;
    @(posedge clk); #1;
    if (ctrl_wr_pulse) pulses++;
  endtask

  task automatic bus_read(input logic [8:0] a, output int lat, output logic [31:0] d,
                          output logic [1:0] resp, output logic rv_next, output logic rv_clear);
    d = 32'hx; resp = 2'b11; rv_next = 1'b0; rv_clear = 1'b0;
    araddr = a; arvalid = 1'b1;
    wait_arready(lat);
    if (lat < 0) begin arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rv_next = rvalid; d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; rv_clear = !rvalid;
  endtask

  task automatic test_reset();
    logic [134:0] outs;
    rst_n = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    net_out = 32'hA5A5_0001; aux_data = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    repeat (3) @(posedge clk); #1;
    outs = {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
            ctrl_reg, cfg0_reg, cfg1_reg, ctrl_wr_pulse};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_writes();
    logic [8:0] addrs [3];
    int lat, pulses, total;
    logic [1:0] resp;
    logic bvn, gone, bvc;
    addrs[0] = 9'h000; addrs[1] = 9'h008; addrs[2] = 9'h00C;
    total = 0;
    foreach (addrs[i]) begin
      bus_write(addrs[i], 32'hDEADBEEF, 4'hF, lat, resp, bvn, gone, pulses, bvc);
      model_write(addrs[i], 32'hDEADBEEF, 4'hF);
      total += pulses;
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL wr_ready_latency addr %h got %0d exp 1", addrs[i], lat); end
      checks++;
      if ({bvn, gone, bvc, resp} !== {3'b111, 2'b00}) begin
        errors++; $display("FAIL wr_handshake addr %h got bv/gone/clr/resp %b exp 11100", addrs[i], {bvn, gone, bvc, resp});
      end
    end
    checks++;
    if ({ctrl_reg, cfg0_reg, cfg1_reg} !== {3{32'hDEADBEEF}}) begin
      errors++; $display("FAIL rw_regs got %h %h %h exp deadbeef", ctrl_reg, cfg0_reg, cfg1_reg);
    end
    checks++;
    if (total !== 1) begin errors++; $display("FAIL ctrl_pulse_count got %0d exp 1", total); end
  endtask

  task automatic test_ro_readback();
    int lat, pulses;
    logic [1:0] resp;
    logic [31:0] d, exp_d;
    logic bvn, gone, bvc, rvn, rvc;
    net_out = $urandom; aux_data = {$urandom, $urandom};
    for (int k = 0; k < 5; k++) begin
      logic [8:0] a;
      a = (k == 0) ? 9'h004 : 9'(12 + 4 * k);
      bus_write(a, 32'hDEADBEEF, 4'hF, lat, resp, bvn, gone, pulses, bvc);
      model_write(a, 32'hDEADBEEF, 4'hF);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL ro_write_resp addr %h got %b exp 00", a, resp); end
    end
    for (int i = 0; i < 8; i++) begin
      logic [8:0] a;
      a = 9'(4 * i);
      exp_d = exp_read(a);
      bus_read(a, lat, d, resp, rvn, rvc);
      checks++;
      if ({d, resp, rvn, rvc} !== {exp_d, 2'b00, 2'b11} || lat !== 1) begin
        errors++; $display("FAIL readback reg %0d got %h/%b/%b%b lat %0d exp %h/00/11 lat 1", i, d, resp, rvn, rvc, lat, exp_d);
      end
    end
  endtask

  task automatic test_wstrb();
    int lat, pulses;
    logic [1:0] resp;
    logic [31:0] d;
    logic bvn, gone, bvc, rvn, rvc;
    bus_write(9'h008, 32'h0, 4'hF, lat, resp, bvn, gone, pulses, bvc);
    model_write(9'h008, 32'h0, 4'hF);
    bus_write(9'h008, 32'h12345678, 4'b0101, lat, resp, bvn, gone, pulses, bvc);
    model_write(9'h008, 32'h12345678, 4'b0101);
    bus_read(9'h008, lat, d, resp, rvn, rvc);
    checks++;
    if (d !== 32'h00340078 || cfg0_reg !== model[2]) begin
      errors++; $display("FAIL wstrb_0101 got rd %h reg %h exp 00340078", d, cfg0_reg);
    end
    bus_write(9'h008, 32'hFFFFFFFF, 4'b0000, lat, resp, bvn, gone, pulses, bvc);
    checks++;
    if (resp !== 2'b00 || cfg0_reg !== 32'h00340078) begin
      errors++; $display("FAIL wstrb_0000 got resp %b reg %h exp 00 00340078", resp, cfg0_reg);
    end
    bus_write(9'h000, 32'h0BADF00D, 4'b0000, lat, resp, bvn, gone, pulses, bvc);
    checks++;
    if (pulses !== 1 || ctrl_reg !== model[0]) begin
      errors++; $display("FAIL ctrl_nostrb_pulse got pulses %0d reg %h exp 1 %h", pulses, ctrl_reg, model[0]);
    end
  endtask

  task automatic test_out_of_range();
    int lat, pulses;
    logic [1:0] resp;
    logic [31:0] d;
    logic bvn, gone, bvc, rvn, rvc;
    logic [8:0] ra [2];
    bus_write(9'h020, 32'h55AA55AA, 4'hF, lat, resp, bvn, gone, pulses, bvc);
    checks++;
    if (resp !== 2'b10 || pulses !== 0) begin errors++; $display("FAIL oor_write got resp %b pulses %0d exp 10 0", resp, pulses); end
    checks++;
    if ({ctrl_reg, cfg0_reg, cfg1_reg} !== {model[0], model[2], model[3]}) begin
      errors++; $display("FAIL oor_no_change got %h %h %h exp %h %h %h", ctrl_reg, cfg0_reg, cfg1_reg, model[0], model[2], model[3]);
    end
    ra[0] = 9'h1FC; ra[1] = 9'h002;
    foreach (ra[i]) begin
      bus_read(ra[i], lat, d, resp, rvn, rvc);
      checks++;
      if (d !== 32'h0 || resp !== 2'b10 || rvn !== 1'b1) begin
        errors++; $display("FAIL oor_read addr %h got %h/%b exp 0/10", ra[i], d, resp);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic stable;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    awaddr = 9'h008; wdata = d1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_awready(lat);
    @(posedge clk); #1;
    model_write(9'h008, d1, 4'hF);
    awaddr = 9'h00C; wdata = d2;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1 || lat !== 1) begin errors++; $display("FAIL bp_hold got stable %b lat %0d exp 1 1", stable, lat); end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_release got bvalid %b exp 0", bvalid); end
    wait_awready(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL bp_second_accept got latency %0d exp 1", lat); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(9'h00C, d2, 4'hF);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checks++;
    if (cfg0_reg !== model[2] || cfg1_reg !== model[3]) begin
      errors++; $display("FAIL bp_regs got %h %h exp %h %h", cfg0_reg, cfg1_reg, model[2], model[3]);
    end
  endtask

  task automatic test_skew();
    int lat;
    logic early;
    logic [31:0] d;
    d = $urandom;
    awaddr = 9'h00C; awvalid = 1'b1; wvalid = 1'b0;
    early = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (awready || wready) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL skew_early_accept got %b exp 0", early); end
    wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    wait_awready(lat);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(9'h00C, d, 4'hF);
    checks++;
    if (lat !== 1 || bvalid !== 1'b1 || cfg1_reg !== model[3]) begin
      errors++; $display("FAIL skew_accept got lat %0d bvalid %b reg %h exp 1 1 %h", lat, bvalid, cfg1_reg, model[3]);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] old_v, d;
    logic both;
    old_v = exp_read(9'h008);
    d = $urandom;
    awaddr = 9'h008; wdata = d; wstrb = 4'hF; araddr = 9'h008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    both = awready && arready;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(9'h008, d, 4'hF);
    checks++;
    if (both !== 1'b1 || rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_v) begin
      errors++; $display("FAIL same_cycle_rw got both %b rd %h exp 1 %h", both, rdata, old_v);
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    checks++;
    if (cfg0_reg !== model[2] || bvalid || rvalid) begin
      errors++; $display("FAIL same_cycle_after got %h exp %h", cfg0_reg, model[2]);
    end
  endtask

  task automatic test_random();
    int lat, pulses;
    logic [1:0] resp, exp_r;
    logic [31:0] d, exp_d;
    logic bvn, gone, bvc, rvn, rvc;
    logic [8:0] a;
    for (int it = 0; it < 40; it++) begin
      net_out = $urandom; aux_data = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) a = 9'($urandom);
      else a = {4'b0, 3'($urandom_range(0, 7)), 2'b00};
      exp_r = addr_ok(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        bus_write(a, d, 4'($urandom), lat, resp, bvn, gone, pulses, bvc);
        model_write(a, d, wstrb);
        checks++;
        if (resp !== exp_r || bvn !== 1'b1) begin
          errors++; $display("FAIL rand_write it %0d addr %h got %b exp %b", it, a, resp, exp_r);
        end
      end else begin
        exp_d = exp_read(a);
        bus_read(a, lat, d, resp, rvn, rvc);
        checks++;
        if (d !== exp_d || resp !== exp_r || rvn !== 1'b1) begin
          errors++; $display("FAIL rand_read it %0d addr %h got %h/%b exp %h/%b", it, a, d, resp, exp_d, exp_r);
        end
      end
    end
    checks++;
    if ({ctrl_reg, cfg0_reg, cfg1_reg} !== {model[0], model[2], model[3]}) begin
      errors++; $display("FAIL rand_final got %h %h %h exp %h %h %h", ctrl_reg, cfg0_reg, cfg1_reg, model[0], model[2], model[3]);
    end
  endtask

  task automatic test_reset_inflight();
    int lat;
    logic pend, quiet;
    logic [134:0] outs;
    logic [31:0] d;
    logic [1:0] resp;
    logic rvn, rvc;
    awaddr = 9'h000; wdata = $urandom | 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_awready(lat);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 9'h008; arvalid = 1'b1;
    wait_arready(lat);
    @(posedge clk); #1;
    arvalid = 1'b0;
    pend = bvalid && rvalid;
    checks++;
    if (pend !== 1'b1) begin errors++; $display("FAIL inflight_setup got %b exp 1", pend); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    outs = {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
            ctrl_reg, cfg0_reg, cfg1_reg, ctrl_wr_pulse};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL inflight_reset got %h exp 0", outs); end
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bvalid || rvalid) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL post_reset_quiet got %b exp 1", quiet); end
    bus_read(9'h000, lat, d, resp, rvn, rvc);
    checks++;
    if (d !== 32'h0 || resp !== 2'b00 || rvn !== 1'b1) begin
      errors++; $display("FAIL post_reset_read got %h/%b exp 0/00", d, resp);
    end
  endtask

  initial begin
    test_reset();
    test_full_writes();
    test_ro_readback();
    test_wstrb();
    test_out_of_range();
    test_backpressure();
    test_skew();
    test_simultaneous();
    test_random();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
